// File: rtl/color_cap_pkg.sv
// Shared types and constants for the colour-sensor capture front end.
// Imported by the capture top and its sequential divider.
package color_cap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL,
        ST_SETTLE,
        ST_GATE,
        ST_SCALE,
        ST_PUBLISH
    } state_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } chan_t;

    localparam logic [1:0] FILT_R = 2'b00;
    localparam logic [1:0] FILT_G = 2'b11;
    localparam logic [1:0] FILT_B = 2'b01;

    localparam logic [7:0] SAT = 8'hFF;

    function automatic logic [1:0] filt_code(input chan_t ch);
        case (ch)
            CH_G:    return FILT_G;
            CH_B:    return FILT_B;
            default: return FILT_R;
        endcase
    endfunction

    function automatic chan_t next_chan(input chan_t ch);
        case (ch)
            CH_R:    return CH_G;
            CH_G:    return CH_B;
            default: return CH_R;
        endcase
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle after a one-cycle load.
// done_o pulses for one cycle with quotient_o valid.
module seq_divider #(
    parameter int DD_W = 28,
    parameter int DS_W = 20
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [DD_W-1:0] dividend_i,
    input  logic [DS_W-1:0] divisor_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [DD_W-1:0] quotient_o
);

    localparam int CW = $clog2(DD_W + 1);

    logic [DS_W-1:0] rem_q, rem_d;
    logic [DS_W-1:0] dvs_q, dvs_d;
    logic [DD_W-1:0] quo_q, quo_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [DS_W:0]   trial;

    always_comb begin
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        trial  = {rem_q, quo_q[DD_W-1]};
        if (start_i && !busy_q) begin
            rem_d  = '0;
            dvs_d  = divisor_i;
            quo_d  = dividend_i;
            cnt_d  = CW'(DD_W);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = DS_W'(trial - {1'b0, dvs_q});
                quo_d = {quo_q[DD_W-2:0], 1'b1};
            end else begin
                rem_d = trial[DS_W-1:0];
                quo_d = {quo_q[DD_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/color_sensor_capture.sv
// TCS3200-style colour sensor driver: per-filter frequency count,
// white-reference normalisation and publication of an 8-bit RGB triple.
module color_sensor_capture
    import color_cap_pkg::*;
#(
    parameter int GATE_CYCLES   = 500_000,
    parameter int SETTLE_CYCLES = 50_000,
    parameter int CNT_W         = 20,
    parameter int WHITE_INIT    = 255
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sensor_out,
    input  logic       cal_white,
    output logic       s0,
    output logic       s1,
    output logic       s2,
    output logic       s3,
    output logic [7:0] data_r,
    output logic [7:0] data_g,
    output logic [7:0] data_b,
    output logic       data_valid,
    output logic       cal_done
);

    localparam int TMAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int DD_W = CNT_W + 8;
    localparam logic [CNT_W-1:0] WINIT = CNT_W'(WHITE_INIT);
    localparam logic [CNT_W-1:0] CMAX  = '1;

    state_t           state_q, state_d;
    chan_t            ch_q, ch_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
    logic [CNT_W-1:0] raw_r_q, raw_g_q, raw_b_q, raw_r_d, raw_g_d, raw_b_d;
    logic [CNT_W-1:0] wht_r_q, wht_g_q, wht_b_q, wht_r_d, wht_g_d, wht_b_d;
    logic [7:0]       res_r_q, res_g_q, res_r_d, res_g_d;
    logic [7:0]       dat_r_q, dat_g_q, dat_b_q, dat_r_d, dat_g_d, dat_b_d;
    logic [1:0]       filt_q, filt_d;
    logic             pend_q, pend_d, calf_q, calf_d;
    logic             cdone_q, cdone_d, div_run_q, div_run_d;
    logic [1:0]       sync_q;
    logic             prev_q, edge_q;

    logic             enter_r, scale_fin, div_start, div_busy, div_done;
    logic [7:0]       scale_res;
    logic [CNT_W-1:0] cur_raw, cur_white;
    logic [DD_W-1:0]  dividend, div_quot;

    always_comb begin
        case (ch_q)
            CH_G:    begin cur_raw = raw_g_q; cur_white = wht_g_q; end
            CH_B:    begin cur_raw = raw_b_q; cur_white = wht_b_q; end
            default: begin cur_raw = raw_r_q; cur_white = wht_r_q; end
        endcase
    end

    // raw * 255 without a multiplier
    assign dividend = ({8'd0, cur_raw} << 8) - {8'd0, cur_raw};

    seq_divider #(.DD_W(DD_W), .DS_W(CNT_W)) u_div (
        .clk_i      (sys_clk),
        .rst_i      (sys_rst),
        .start_i    (div_start),
        .dividend_i (dividend),
        .divisor_i  (cur_white),
        .busy_o     (div_busy),
        .done_o     (div_done),
        .quotient_o (div_quot)
    );

    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        tmr_d     = tmr_q;
        cnt_d     = cnt_q;
        raw_r_d   = raw_r_q;
        raw_g_d   = raw_g_q;
        raw_b_d   = raw_b_q;
        wht_r_d   = wht_r_q;
        wht_g_d   = wht_g_q;
        wht_b_d   = wht_b_q;
        res_r_d   = res_r_q;
        res_g_d   = res_g_q;
        dat_r_d   = dat_r_q;
        dat_g_d   = dat_g_q;
        dat_b_d   = dat_b_q;
        filt_d    = filt_q;
        pend_d    = pend_q | cal_white;
        calf_d    = calf_q;
        cdone_d   = cdone_q;
        div_run_d = div_run_q;
        enter_r   = 1'b0;
        scale_fin = 1'b0;
        scale_res = 8'h00;
        div_start = 1'b0;
        cnt_nxt   = cnt_q;
        if (edge_q && cnt_q != CMAX) cnt_nxt = cnt_q + CNT_W'(1);

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_SEL;
                ch_d    = CH_R;
                enter_r = 1'b1;
            end
            ST_SEL: begin
                filt_d  = filt_code(ch_q);
                cnt_d   = '0;
                tmr_d   = TW'(SETTLE_CYCLES - 1);
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (tmr_q == '0) begin
                    tmr_d   = TW'(GATE_CYCLES - 1);
                    state_d = ST_GATE;
                end else begin
                    tmr_d = tmr_q - TW'(1);
                end
            end
            ST_GATE: begin
                cnt_d = cnt_nxt;
                if (tmr_q != '0) begin
                    tmr_d = tmr_q - TW'(1);
                end else begin
                    case (ch_q)
                        CH_G:    raw_g_d = cnt_nxt;
                        CH_B:    raw_b_d = cnt_nxt;
                        default: raw_r_d = cnt_nxt;
                    endcase
                    if (ch_q != CH_B) begin
                        ch_d    = next_chan(ch_q);
                        state_d = ST_SEL;
                    end else if (calf_q) begin
                        wht_r_d = raw_r_q;
                        wht_g_d = raw_g_q;
                        wht_b_d = cnt_nxt;
                        cdone_d = 1'b1;
                        calf_d  = 1'b0;
                        ch_d    = CH_R;
                        state_d = ST_SEL;
                        enter_r = 1'b1;
                    end else begin
                        ch_d    = CH_R;
                        state_d = ST_SCALE;
                    end
                end
            end
            ST_SCALE: begin
                if (!div_run_q) begin
                    if (cur_white == '0) begin
                        scale_fin = 1'b1;
                        scale_res = (cur_raw == '0) ? 8'h00 : SAT;
                    end else if (cur_raw >= cur_white) begin
                        scale_fin = 1'b1;
                        scale_res = SAT;
                    end else if (!div_busy) begin
                        div_start = 1'b1;
                        div_run_d = 1'b1;
                    end
                end else if (div_done) begin
                    scale_fin = 1'b1;
                    div_run_d = 1'b0;
                    scale_res = (div_quot[DD_W-1:8] != '0) ? SAT : div_quot[7:0];
                end
                if (scale_fin) begin
                    case (ch_q)
                        CH_R: begin
                            res_r_d = scale_res;
                            ch_d    = CH_G;
                        end
                        CH_G: begin
                            res_g_d = scale_res;
                            ch_d    = CH_B;
                        end
                        default: begin
                            dat_r_d = res_r_q;
                            dat_g_d = res_g_q;
                            dat_b_d = scale_res;
                            ch_d    = CH_R;
                            state_d = ST_PUBLISH;
                        end
                    endcase
                end
            end
            ST_PUBLISH: begin
                state_d = ST_SEL;
                ch_d    = CH_R;
                enter_r = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase

        // a request arriving on the very entry edge still claims this frame
        if (enter_r) begin
            calf_d = pend_q | cal_white;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= ST_IDLE;
            ch_q      <= CH_R;
            tmr_q     <= '0;
            cnt_q     <= '0;
            raw_r_q   <= '0;
            raw_g_q   <= '0;
            raw_b_q   <= '0;
            wht_r_q   <= WINIT;
            wht_g_q   <= WINIT;
            wht_b_q   <= WINIT;
            res_r_q   <= '0;
            res_g_q   <= '0;
            dat_r_q   <= '0;
            dat_g_q   <= '0;
            dat_b_q   <= '0;
            filt_q    <= FILT_R;
            pend_q    <= 1'b0;
            calf_q    <= 1'b0;
            cdone_q   <= 1'b0;
            div_run_q <= 1'b0;
            sync_q    <= '0;
            prev_q    <= 1'b0;
            edge_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            tmr_q     <= tmr_d;
            cnt_q     <= cnt_d;
            raw_r_q   <= raw_r_d;
            raw_g_q   <= raw_g_d;
            raw_b_q   <= raw_b_d;
            wht_r_q   <= wht_r_d;
            wht_g_q   <= wht_g_d;
            wht_b_q   <= wht_b_d;
            res_r_q   <= res_r_d;
            res_g_q   <= res_g_d;
            dat_r_q   <= dat_r_d;
            dat_g_q   <= dat_g_d;
            dat_b_q   <= dat_b_d;
            filt_q    <= filt_d;
            pend_q    <= pend_d;
            calf_q    <= calf_d;
            cdone_q   <= cdone_d;
            div_run_q <= div_run_d;
            sync_q    <= {sync_q[0], sensor_out};
            prev_q    <= sync_q[1];
            edge_q    <= sync_q[1] & ~prev_q;
        end
    end

    assign s0         = 1'b1;
    assign s1         = 1'b0;
    assign {s2, s3}   = filt_q;
    assign data_r     = dat_r_q;
    assign data_g     = dat_g_q;
    assign data_b     = dat_b_q;
    assign data_valid = (state_q == ST_PUBLISH);
    assign cal_done   = cdone_q;

endmodule
